// File: rtl/pos_smoother.sv
// Position smoother: clamps a centred signed position into LCD pixel
// coordinates, averages the last four samples per axis, and blanks the
// on-screen marker when no new position has arrived for TIMEOUT cycles.
module pos_smoother #(
   parameter int SCR_W   = 480,
   parameter int SCR_H   = 272,
   parameter int TIMEOUT = 12_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ena,
   input  logic signed [25:0] x_in,
   input  logic signed [25:0] y_in,
   output logic        [15:0] pix_x,
   output logic        [15:0] pix_y,
   output logic               out_valid,
   output logic               marker_on,
   output logic        [7:0]  drop_cnt
);

   typedef enum logic [2:0] {IDLE, CLAMP, ACCUM, DIVIDE, OUT} state_t;

   localparam logic signed [26:0] HALF_W   = 27'(SCR_W / 2);
   localparam logic signed [26:0] HALF_H   = 27'(SCR_H / 2);
   localparam logic signed [26:0] MAX_X    = 27'(SCR_W - 1);
   localparam logic signed [26:0] MAX_Y    = 27'(SCR_H - 1);
   localparam logic        [23:0] TMO_LAST = 24'(TIMEOUT - 1);

   state_t state, next_state;

   logic signed [25:0] cap_x, cap_y;
   logic signed [26:0] xs, ys;
   logic        [15:0] clamp_x_d, clamp_y_d;
   logic        [15:0] clamp_x, clamp_y;
   logic        [15:0] buf_x [4];
   logic        [15:0] buf_y [4];
   logic        [1:0]  wp;
   logic        [17:0] sum_x, sum_y;
   logic        [15:0] avg_x, avg_y;
   logic               buf_empty;
   logic        [23:0] tmo_cnt;
   logic               accept;

   assign accept = (state == IDLE) && ena;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state logic: one cycle per processing stage once a sample is taken.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (ena) next_state = CLAMP;
         CLAMP:   next_state = ACCUM;
         ACCUM:   next_state = DIVIDE;
         DIVIDE:  next_state = OUT;
         OUT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Shift the centred sample to screen coordinates and clamp to the panel.
   always_comb begin
      xs = {cap_x[25], cap_x} + HALF_W;
      ys = {cap_y[25], cap_y} + HALF_H;
      if (xs[26])          clamp_x_d = '0;
      else if (xs > MAX_X) clamp_x_d = MAX_X[15:0];
      else                 clamp_x_d = xs[15:0];
      if (ys[26])          clamp_y_d = '0;
      else if (ys > MAX_Y) clamp_y_d = MAX_Y[15:0];
      else                 clamp_y_d = ys[15:0];
   end

   // Datapath: capture, clamp, ring-buffer running sum, divide, present.
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_x     <= '0;
         cap_y     <= '0;
         clamp_x   <= '0;
         clamp_y   <= '0;
         wp        <= '0;
         sum_x     <= '0;
         sum_y     <= '0;
         avg_x     <= '0;
         avg_y     <= '0;
         pix_x     <= '0;
         pix_y     <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < 4; i++) begin
            buf_x[i] <= '0;
            buf_y[i] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         if (accept) begin
            cap_x <= x_in;
            cap_y <= y_in;
         end
         case (state)
            CLAMP: begin
               clamp_x <= clamp_x_d;
               clamp_y <= clamp_y_d;
            end
            ACCUM: begin
               if (buf_empty) begin
                  for (int i = 0; i < 4; i++) begin
                     buf_x[i] <= clamp_x;
                     buf_y[i] <= clamp_y;
                  end
                  sum_x <= {clamp_x, 2'b00};
                  sum_y <= {clamp_y, 2'b00};
                  wp    <= 2'd1;
               end else begin
                  buf_x[wp] <= clamp_x;
                  buf_y[wp] <= clamp_y;
                  sum_x     <= sum_x + {2'b00, clamp_x} - {2'b00, buf_x[wp]};
                  sum_y     <= sum_y + {2'b00, clamp_y} - {2'b00, buf_y[wp]};
                  wp        <= wp + 2'd1;
               end
            end
            DIVIDE: begin
               avg_x <= sum_x[17:2];
               avg_y <= sum_y[17:2];
            end
            OUT: begin
               pix_x     <= avg_x;
               pix_y     <= avg_y;
               out_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Status: drop counter, freshness timeout, marker and buffer-empty flag.
   // The timeout counter also runs while a sample is in flight so the marker
   // expires a fixed number of cycles after the last accepted strobe.
   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt  <= '0;
         tmo_cnt   <= '0;
         marker_on <= 1'b0;
         buf_empty <= 1'b1;
      end else begin
         if (ena && (state != IDLE) && (drop_cnt != 8'hFF))
            drop_cnt <= drop_cnt + 8'd1;
         if (accept)
            tmo_cnt <= '0;
         else if ((marker_on || (state != IDLE)) && (tmo_cnt != TMO_LAST))
            tmo_cnt <= tmo_cnt + 24'd1;
         if (!accept && marker_on && (tmo_cnt == TMO_LAST)) begin
            marker_on <= 1'b0;
            buf_empty <= 1'b1;
         end
         if (state == ACCUM)
            buf_empty <= 1'b0;
         if (state == OUT)
            marker_on <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pos_smoother.sv
// Scoreboard bench for pos_smoother: a driver feeds strobes and pushes the
// expected smoothed coordinates; a monitor pops them whenever out_valid fires.
module tb_pos_smoother;

   localparam int TMO = 100;

   logic               clk = 1'b0;
   logic               rst;
   logic               ena;
   logic signed [25:0] x_in, y_in;
   logic        [15:0] pix_x, pix_y;
   logic               out_valid, marker_on;
   logic        [7:0]  drop_cnt;

   pos_smoother #(.SCR_W(480), .SCR_H(272), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ena(ena), .x_in(x_in), .y_in(y_in),
      .pix_x(pix_x), .pix_y(pix_y), .out_valid(out_valid),
      .marker_on(marker_on), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {int edge_no; int px; int py;} exp_t;
   exp_t expq[$];

   // Reference model state: the last four clamped samples per axis.
   int  hist_x[$];
   int  hist_y[$];
   bit  fresh    = 0;
   int  last_acc = 0;
   int  busy_end = 0;
   int  drops_m  = 0;

   function automatic int clampv(int v, int half, int maxv);
      int s;
      s = v + half;
      if (s < 0)    return 0;
      if (s > maxv) return maxv;
      return s;
   endfunction

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Drive one clock edge worth of input and update the model.
   task automatic applyStimulus(input bit e, input int xv, input int yv);
      int ed, cx, cy, sx, sy;
      @(negedge clk);
      ena  = e;
      x_in = 26'(xv);
      y_in = 26'(yv);
      ed   = cyc + 1;
      if (e) begin
         if (ed >= busy_end) begin
            cx = clampv(xv, 240, 479);
            cy = clampv(yv, 136, 271);
            if (!fresh || (ed - last_acc > TMO)) begin
               hist_x.delete();
               hist_y.delete();
               repeat (4) begin
                  hist_x.push_back(cx);
                  hist_y.push_back(cy);
               end
            end else begin
               hist_x.push_back(cx);
               hist_y.push_back(cy);
               void'(hist_x.pop_front());
               void'(hist_y.pop_front());
            end
            sx = 0;
            sy = 0;
            foreach (hist_x[i]) sx += hist_x[i];
            foreach (hist_y[i]) sy += hist_y[i];
            expq.push_back('{ed + 4, sx / 4, sy / 4});
            fresh    = 1;
            last_acc = ed;
            busy_end = ed + 5;
         end else if (drops_m < 255) begin
            drops_m++;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(0, 0, 0);
   endtask

   task automatic resetDut();
      @(negedge clk);
      rst  = 1'b1;
      ena  = 1'b0;
      expq.delete();
      fresh    = 0;
      busy_end = 0;
      drops_m  = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   function automatic int randCoord(input int span);
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) return -33554432;
      if (r == 1) return 33554431;
      return int'($urandom_range(0, 2 * span)) - span;
   endfunction

   // Monitor: every out_valid must match the next expected result and edge.
   initial begin
      exp_t t;
      forever begin
         @(posedge clk);
         #1;
         if (out_valid) begin
            if (expq.size() == 0) begin
               total++;
               bad++;
               $display("[TB] FAIL unexpected_out_valid: got 1 expected 0 at edge %0d", cyc);
            end else begin
               t = expq.pop_front();
               checkOutput("out_edge", cyc, t.edge_no);
               checkOutput("pix_x", int'(pix_x), t.px);
               checkOutput("pix_y", int'(pix_y), t.py);
               checkOutput("marker_at_out", int'(marker_on), 1);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios followed by randomized traffic.
   initial begin
      rst  = 1'b1;
      ena  = 1'b0;
      x_in = '0;
      y_in = '0;
      resetDut();
      checkOutput("rst_pix_x", int'(pix_x), 0);
      checkOutput("rst_pix_y", int'(pix_y), 0);
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_marker", int'(marker_on), 0);
      checkOutput("rst_drop_cnt", int'(drop_cnt), 0);

      $display("[TB] centre sample and running average");
      applyStimulus(1, 0, 0);
      idle(5);
      checkOutput("centre_x", int'(pix_x), 240);
      checkOutput("centre_y", int'(pix_y), 136);
      checkOutput("centre_marker", int'(marker_on), 1);
      checkOutput("centre_valid", int'(out_valid), 1);
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(1, 40, 0);
         idle(5);
         checkOutput("avg_step_x", int'(pix_x), 240 + 10 * k);
      end

      $display("[TB] clamping on empty buffer");
      resetDut();
      applyStimulus(1, -1000, 5000);
      idle(5);
      checkOutput("clamp_x", int'(pix_x), 0);
      checkOutput("clamp_y", int'(pix_y), 271);

      $display("[TB] back-to-back strobes");
      resetDut();
      applyStimulus(1, 10, 10);
      applyStimulus(1, 20, 20);
      idle(6);
      checkOutput("single_drop", int'(drop_cnt), 1);

      $display("[TB] timeout");
      resetDut();
      applyStimulus(1, 0, 0);
      idle(100);
      checkOutput("marker_before_tmo", int'(marker_on), 1);
      idle(1);
      checkOutput("marker_after_tmo", int'(marker_on), 0);
      checkOutput("hold_x", int'(pix_x), 240);
      checkOutput("hold_y", int'(pix_y), 136);
      applyStimulus(1, 100, 0);
      idle(5);
      checkOutput("reprime_x", int'(pix_x), 340);
      checkOutput("reprime_marker", int'(marker_on), 1);
      idle(94);
      applyStimulus(1, 200, 0);
      idle(5);
      checkOutput("ena_wins_x", int'(pix_x), 365);
      checkOutput("ena_wins_marker", int'(marker_on), 1);

      $display("[TB] reset during accumulate");
      applyStimulus(1, 50, 50);
      applyStimulus(0, 0, 0);
      resetDut();
      checkOutput("abort_pix_x", int'(pix_x), 0);
      checkOutput("abort_marker", int'(marker_on), 0);
      checkOutput("abort_valid", int'(out_valid), 0);
      idle(8);
      applyStimulus(1, 100, 0);
      idle(5);
      checkOutput("abort_prime_x", int'(pix_x), 340);
      checkOutput("abort_prime_y", int'(pix_y), 136);

      $display("[TB] randomized traffic");
      resetDut();
      for (int n = 0; n < 300; n++) begin
         int r;
         r = int'($urandom_range(0, 99));
         if (r < 40)      applyStimulus(1, randCoord(500), randCoord(400));
         else if (r < 42) idle(int'($urandom_range(99, 103)));
         else             applyStimulus(0, 0, 0);
      end
      idle(6);
      checkOutput("rand_drop_cnt", int'(drop_cnt), drops_m);

      $display("[TB] drop counter saturation");
      repeat (400) applyStimulus(1, randCoord(500), randCoord(400));
      idle(6);
      checkOutput("drop_sat", int'(drop_cnt), 255);
      checkOutput("drop_sat_model", int'(drop_cnt), drops_m);

      idle(6);
      checkOutput("queue_drained", expq.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
